// File: rtl/jtframe_vtgen.sv
// jtframe_vtgen: programmable raw video timing generator.
// Produces H/V pixel counters, active-low blanking, active-high syncs,
// line/frame start strobes and a frame parity bit. Every register only
// moves on clock edges qualified by pxl_cen, and every flag is computed
// from the counter values being loaded on that same edge, so the flags
// always line up with the H/V values they are registered alongside.
module jtframe_vtgen #(
  parameter int HCNTW    = 9,
  parameter int VCNTW    = 9,
  parameter int H_TOTAL  = 383,
  parameter int HB_START = 256,
  parameter int HB_END   = 0,
  parameter int HS_START = 304,
  parameter int HS_END   = 336,
  parameter int V_TOTAL  = 261,
  parameter int VB_START = 224,
  parameter int VB_END   = 0,
  parameter int VS_START = 240,
  parameter int VS_END   = 243
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pxl_cen,
  output logic [HCNTW-1:0] H,
  output logic [VCNTW-1:0] V,
  output logic             LHBL,
  output logic             LVBL,
  output logic             HS,
  output logic             VS,
  output logic             HINIT,
  output logic             VINIT,
  output logic             field
);

  // Timing points resized to the counter widths so every compare is width-exact.
  localparam logic [HCNTW-1:0] L_H_TOTAL  = HCNTW'(H_TOTAL);
  localparam logic [HCNTW-1:0] L_HB_START = HCNTW'(HB_START);
  localparam logic [HCNTW-1:0] L_HB_END   = HCNTW'(HB_END);
  localparam logic [HCNTW-1:0] L_HS_START = HCNTW'(HS_START);
  localparam logic [HCNTW-1:0] L_HS_END   = HCNTW'(HS_END);
  localparam logic [VCNTW-1:0] L_V_TOTAL  = VCNTW'(V_TOTAL);
  localparam logic [VCNTW-1:0] L_VB_START = VCNTW'(VB_START);
  localparam logic [VCNTW-1:0] L_VB_END   = VCNTW'(VB_END);
  localparam logic [VCNTW-1:0] L_VS_START = VCNTW'(VS_START);
  localparam logic [VCNTW-1:0] L_VS_END   = VCNTW'(VS_END);

  logic [HCNTW-1:0] r_hCnt;
  logic [VCNTW-1:0] r_vCnt;
  logic             r_lhbl;
  logic             r_lvbl;
  logic             r_hs;
  logic             r_vs;
  logic             r_hinit;
  logic             r_vinit;
  logic             r_field;

  logic             w_hWrap;
  logic [HCNTW-1:0] w_hNext;
  logic [VCNTW-1:0] w_vNext;
  logic             w_hZero;
  logic             w_frameStart;

  // Compute the counter values that the next pixel enable will load.
  always_comb begin
    w_hWrap      = (r_hCnt == L_H_TOTAL);
    w_hNext      = r_hCnt + HCNTW'(1);
    w_vNext      = r_vCnt;
    if (w_hWrap) begin
      w_hNext = '0;
      if (r_vCnt == L_V_TOTAL) begin
        w_vNext = '0;
      end else begin
        w_vNext = r_vCnt + VCNTW'(1);
      end
    end
    w_hZero      = (w_hNext == '0);
    w_frameStart = w_hZero && (w_vNext == '0);
  end

  // Pixel and line counters; V only moves when H wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hCnt <= '0;
      r_vCnt <= '0;
    end else if (pxl_cen) begin
      r_hCnt <= w_hNext;
      r_vCnt <= w_vNext;
    end
  end

  // Horizontal blank and sync; a clear on the same H as a set takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lhbl <= 1'b0;
      r_hs   <= 1'b0;
    end else if (pxl_cen) begin
      if (w_hNext == L_HB_START) begin
        r_lhbl <= 1'b0;
      end else if (w_hNext == L_HB_END) begin
        r_lhbl <= 1'b1;
      end
      if (w_hNext == L_HS_END) begin
        r_hs <= 1'b0;
      end else if (w_hNext == L_HS_START) begin
        r_hs <= 1'b1;
      end
    end
  end

  // Vertical blank moves with the H blank start and vertical sync with the H sync start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lvbl <= 1'b0;
      r_vs   <= 1'b0;
    end else if (pxl_cen) begin
      if (w_hNext == L_HB_START) begin
        if (w_vNext == L_VB_START) begin
          r_lvbl <= 1'b0;
        end else if (w_vNext == L_VB_END) begin
          r_lvbl <= 1'b1;
        end
      end
      if (w_hNext == L_HS_START) begin
        if (w_vNext == L_VS_END) begin
          r_vs <= 1'b0;
        end else if (w_vNext == L_VS_START) begin
          r_vs <= 1'b1;
        end
      end
    end
  end

  // Line/frame start strobes and the frame parity bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hinit <= 1'b0;
      r_vinit <= 1'b0;
      r_field <= 1'b0;
    end else if (pxl_cen) begin
      r_hinit <= w_hZero;
      r_vinit <= w_frameStart;
      if (w_frameStart) begin
        r_field <= ~r_field;
      end
    end
  end

  assign H     = r_hCnt;
  assign V     = r_vCnt;
  assign LHBL  = r_lhbl;
  assign LVBL  = r_lvbl;
  assign HS    = r_hs;
  assign VS    = r_vs;
  assign HINIT = r_hinit;
  assign VINIT = r_vinit;
  assign field = r_field;

endmodule

// File: tb/tb_jtframe_vtgen.sv
// tb_jtframe_vtgen: directed self-checking bench for the timing generator,
// using a 12x8 raster so whole frames run quickly.
module tb_jtframe_vtgen;

  logic       clk;
  logic       rst_n;
  logic       pxl_cen;
  logic [3:0] H;
  logic [3:0] V;
  logic       LHBL;
  logic       LVBL;
  logic       HS;
  logic       VS;
  logic       HINIT;
  logic       VINIT;
  logic       field;

  int   checks;
  int   failures;
  int   mH;
  int   mV;
  logic mField;
  int   ticksSinceReset;

  jtframe_vtgen #(
    .HCNTW(4), .VCNTW(4), .H_TOTAL(11), .HB_START(8), .HB_END(0),
    .HS_START(9), .HS_END(10), .V_TOTAL(7), .VB_START(5), .VB_END(0),
    .VS_START(6), .VS_END(7)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .H(H), .V(V),
    .LHBL(LHBL), .LVBL(LVBL), .HS(HS), .VS(VS), .HINIT(HINIT),
    .VINIT(VINIT), .field(field)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Raster position model: 12 pixels per line, 8 lines per frame.
  task automatic advanceModel();
    if (mH == 11) begin
      mH = 0;
      mV = (mV == 7) ? 0 : mV + 1;
    end else begin
      mH = mH + 1;
    end
    if (mH == 0 && mV == 0) mField = ~mField;
  endtask

  // One clock with the given enable; returns at the following falling edge.
  task automatic tick(input logic cen);
    pxl_cen = cen;
    @(negedge clk);
    if (cen) begin
      advanceModel();
      ticksSinceReset++;
    end
  endtask

  // Expected windows in the steady-state raster.
  function automatic logic expLhbl(int h);
    return !(h >= 8);
  endfunction

  function automatic logic expHs(int h);
    return (h == 9);
  endfunction

  function automatic logic expLvbl(int h, int v);
    return !((v == 5 && h >= 8) || v == 6 || v == 7 || (v == 0 && h < 8));
  endfunction

  function automatic logic expVs(int h, int v);
    return (v == 6 && h >= 9) || (v == 7 && h < 9);
  endfunction

  task automatic test_reset();
    rst_n   = 1'b0;
    pxl_cen = 1'b1;
    repeat (3) @(negedge clk);
    checks += 9;
    if (H !== 4'd0)    begin failures++; $display("[TB] FAIL reset_H got %0d want 0", H); end
    if (V !== 4'd0)    begin failures++; $display("[TB] FAIL reset_V got %0d want 0", V); end
    if (LHBL !== 1'b0) begin failures++; $display("[TB] FAIL reset_LHBL got %b want 0", LHBL); end
    if (LVBL !== 1'b0) begin failures++; $display("[TB] FAIL reset_LVBL got %b want 0", LVBL); end
    if (HS !== 1'b0)   begin failures++; $display("[TB] FAIL reset_HS got %b want 0", HS); end
    if (VS !== 1'b0)   begin failures++; $display("[TB] FAIL reset_VS got %b want 0", VS); end
    if (HINIT !== 1'b0) begin failures++; $display("[TB] FAIL reset_HINIT got %b want 0", HINIT); end
    if (VINIT !== 1'b0) begin failures++; $display("[TB] FAIL reset_VINIT got %b want 0", VINIT); end
    if (field !== 1'b0) begin failures++; $display("[TB] FAIL reset_field got %b want 0", field); end
    rst_n = 1'b1;
    mH = 0; mV = 0; mField = 1'b0; ticksSinceReset = 0;
  endtask

  task automatic test_counters();
    for (int t = 0; t < 192; t++) begin
      tick(1'b1);
      checks += 5;
      if (H !== 4'(mH)) begin failures++; $display("[TB] FAIL cnt_H got %0d want %0d", H, mH); end
      if (V !== 4'(mV)) begin failures++; $display("[TB] FAIL cnt_V got %0d want %0d", V, mV); end
      if (HINIT !== (mH == 0)) begin failures++; $display("[TB] FAIL cnt_HINIT got %b at H=%0d", HINIT, mH); end
      if (VINIT !== (mH == 0 && mV == 0)) begin failures++; $display("[TB] FAIL cnt_VINIT got %b at H=%0d V=%0d", VINIT, mH, mV); end
      if (field !== mField) begin failures++; $display("[TB] FAIL cnt_field got %b want %b", field, mField); end
      if (ticksSinceReset < 12) begin
        checks++;
        if (LHBL !== 1'b0) begin failures++; $display("[TB] FAIL first_line_LHBL got %b want 0 at H=%0d", LHBL, mH); end
      end
    end
  endtask

  task automatic test_cen_gaps();
    for (int p = 0; p < 36; p++) begin
      for (int k = 0; k < 3; k++) begin
        tick(k == 0);
        checks += 8;
        if (H !== 4'(mH)) begin failures++; $display("[TB] FAIL gap_H got %0d want %0d", H, mH); end
        if (V !== 4'(mV)) begin failures++; $display("[TB] FAIL gap_V got %0d want %0d", V, mV); end
        if (HINIT !== (mH == 0)) begin failures++; $display("[TB] FAIL gap_HINIT got %b at H=%0d", HINIT, mH); end
        if (LHBL !== expLhbl(mH)) begin failures++; $display("[TB] FAIL gap_LHBL got %b at H=%0d", LHBL, mH); end
        if (HS !== expHs(mH)) begin failures++; $display("[TB] FAIL gap_HS got %b at H=%0d", HS, mH); end
        if (LVBL !== expLvbl(mH, mV)) begin failures++; $display("[TB] FAIL gap_LVBL got %b at H=%0d V=%0d", LVBL, mH, mV); end
        if (VS !== expVs(mH, mV)) begin failures++; $display("[TB] FAIL gap_VS got %b at H=%0d V=%0d", VS, mH, mV); end
        if (field !== mField) begin failures++; $display("[TB] FAIL gap_field got %b want %b", field, mField); end
      end
    end
  endtask

  task automatic test_hblank_hsync();
    int blankCnt;
    int syncCnt;
    blankCnt = 0;
    syncCnt  = 0;
    for (int t = 0; t < 96; t++) begin
      tick(1'b1);
      checks += 2;
      if (LHBL !== expLhbl(mH)) begin failures++; $display("[TB] FAIL hb_LHBL got %b at H=%0d", LHBL, mH); end
      if (HS !== expHs(mH)) begin failures++; $display("[TB] FAIL hs_HS got %b at H=%0d", HS, mH); end
      if (mV == 3) begin
        if (LHBL === 1'b0) blankCnt++;
        if (HS === 1'b1) syncCnt++;
      end
    end
    checks += 2;
    if (blankCnt != 4) begin failures++; $display("[TB] FAIL hb_width got %0d want 4", blankCnt); end
    if (syncCnt != 1) begin failures++; $display("[TB] FAIL hs_width got %0d want 1", syncCnt); end
  endtask

  task automatic test_vblank_vsync();
    int   toggles;
    logic prevField;
    toggles   = 0;
    prevField = field;
    for (int t = 0; t < 192; t++) begin
      tick(1'b1);
      checks += 2;
      if (LVBL !== expLvbl(mH, mV)) begin failures++; $display("[TB] FAIL vb_LVBL got %b at H=%0d V=%0d", LVBL, mH, mV); end
      if (VS !== expVs(mH, mV)) begin failures++; $display("[TB] FAIL vs_VS got %b at H=%0d V=%0d", VS, mH, mV); end
      if (field !== prevField) begin
        toggles++;
        checks++;
        if (VINIT !== 1'b1) begin failures++; $display("[TB] FAIL field_at_vinit got VINIT=%b at H=%0d V=%0d", VINIT, mH, mV); end
      end
      prevField = field;
    end
    checks++;
    if (toggles != 2) begin failures++; $display("[TB] FAIL field_toggles got %0d want 2", toggles); end
  endtask

  task automatic test_async_reset();
    bit found;
    found = 1'b0;
    for (int t = 0; t < 200 && !found; t++) begin
      tick(1'b1);
      if (mV == 6 && mH == 10) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++; $display("[TB] FAIL rst_locate got no line6/H10 want found");
    end else begin
      checks += 2;
      if (VS !== 1'b1) begin failures++; $display("[TB] FAIL pre_rst_VS got %b want 1", VS); end
      if (LHBL !== 1'b0) begin failures++; $display("[TB] FAIL pre_rst_LHBL got %b want 0", LHBL); end
    end
    pxl_cen = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks += 5;
    if (H !== 4'd0 || V !== 4'd0) begin failures++; $display("[TB] FAIL async_HV got H=%0d V=%0d want 0", H, V); end
    if (VS !== 1'b0) begin failures++; $display("[TB] FAIL async_VS got %b want 0", VS); end
    if (LHBL !== 1'b0 || LVBL !== 1'b0) begin failures++; $display("[TB] FAIL async_blank got %b%b want 00", LHBL, LVBL); end
    if (HS !== 1'b0) begin failures++; $display("[TB] FAIL async_HS got %b want 0", HS); end
    if (HINIT !== 1'b0 || VINIT !== 1'b0 || field !== 1'b0) begin failures++; $display("[TB] FAIL async_misc got %b%b%b want 000", HINIT, VINIT, field); end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (H !== 4'd0 || VS !== 1'b0) begin failures++; $display("[TB] FAIL held_rst got H=%0d VS=%b want 0/0", H, VS); end
    rst_n = 1'b1;
    mH = 0; mV = 0; mField = 1'b0; ticksSinceReset = 0;
    for (int k = 1; k <= 3; k++) begin
      tick(1'b1);
      checks += 2;
      if (H !== 4'(k)) begin failures++; $display("[TB] FAIL resume_H got %0d want %0d", H, k); end
      if (V !== 4'd0) begin failures++; $display("[TB] FAIL resume_V got %0d want 0", V); end
    end
  endtask

  task automatic test_frame_period();
    int       vinitTick[4];
    int       n;
    int       offset;
    int       fi;
    int       diffs;
    logic [3:0] cur;
    logic [3:0] prev;
    logic [3:0] sig[2][96];
    int       edgeCnt[2][4];
    n = 0;
    diffs = 0;
    for (int a = 0; a < 2; a++) begin
      for (int b = 0; b < 4; b++) edgeCnt[a][b] = 0;
      for (int b = 0; b < 96; b++) sig[a][b] = 4'h0;
    end
    prev = {LHBL, HS, LVBL, VS};
    for (int t = 0; t < 400 && n < 4; t++) begin
      tick(1'b1);
      cur = {LHBL, HS, LVBL, VS};
      if (VINIT === 1'b1) begin
        vinitTick[n] = t;
        n++;
      end
      if (n == 2 || n == 3) begin
        fi = n - 2;
        offset = t - vinitTick[n-1];
        if (offset < 96) sig[fi][offset] = cur;
        for (int b = 0; b < 4; b++) if (cur[b] !== prev[b]) edgeCnt[fi][b]++;
      end
      prev = cur;
    end
    checks++;
    if (n < 4) begin
      failures++; $display("[TB] FAIL vinit_count got %0d want 4", n);
    end else begin
      checks += 3;
      if (vinitTick[2] - vinitTick[1] != 96) begin failures++; $display("[TB] FAIL period_f2 got %0d want 96", vinitTick[2] - vinitTick[1]); end
      if (vinitTick[3] - vinitTick[2] != 96) begin failures++; $display("[TB] FAIL period_f3 got %0d want 96", vinitTick[3] - vinitTick[2]); end
      for (int b = 0; b < 96; b++) if (sig[0][b] !== sig[1][b]) diffs++;
      if (diffs != 0) begin failures++; $display("[TB] FAIL frame_repeat got %0d differing pixels want 0", diffs); end
      for (int f = 0; f < 2; f++) begin
        checks += 4;
        if (edgeCnt[f][3] != 16) begin failures++; $display("[TB] FAIL edges_LHBL f%0d got %0d want 16", f + 2, edgeCnt[f][3]); end
        if (edgeCnt[f][2] != 16) begin failures++; $display("[TB] FAIL edges_HS f%0d got %0d want 16", f + 2, edgeCnt[f][2]); end
        if (edgeCnt[f][1] != 2) begin failures++; $display("[TB] FAIL edges_LVBL f%0d got %0d want 2", f + 2, edgeCnt[f][1]); end
        if (edgeCnt[f][0] != 2) begin failures++; $display("[TB] FAIL edges_VS f%0d got %0d want 2", f + 2, edgeCnt[f][0]); end
      end
    end
  endtask

  // Run every scenario in order and report.
  initial begin
    checks = 0;
    failures = 0;
    mH = 0; mV = 0; mField = 1'b0; ticksSinceReset = 0;
    rst_n = 1'b0;
    pxl_cen = 1'b0;
    @(negedge clk);
    test_reset();
    test_counters();
    test_cen_gaps();
    test_hblank_hsync();
    test_vblank_vsync();
    test_async_reset();
    test_frame_period();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
